// File: rtl/tweet_buffer_ctrl_if.sv
// Host-side signal bundle of the tweetboard UART recorder/player.
// The master drives the controls and serial input; the slave is the recorder.
interface tweet_buffer_ctrl_if #(
  parameter int DEPTH_LOG2 = 8
);
  logic                  enable;
  logic                  clear;
  logic                  play;
  logic                  rx_in;
  logic                  tx_out;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  rx_busy;
  logic                  playing;
  logic                  overflow;
  logic                  frame_err;

  modport master (
    output enable, clear, play, rx_in,
    input  tx_out, count, full, rx_busy, playing, overflow, frame_err
  );

  modport slave (
    input  enable, clear, play, rx_in,
    output tx_out, count, full, rx_busy, playing, overflow, frame_err
  );
endinterface

// File: rtl/tweet_buffer_ctrl.sv
// UART message recorder/player: stores received 8N1 characters, optionally
// echoes them, and replays the whole buffer with a gap between characters.
module tweet_buffer_ctrl #(
  parameter int BAUD_DIV   = 5208,
  parameter int DEPTH_LOG2 = 8,
  parameter int GAP_CYCLES = 52070,
  parameter bit ECHO       = 1'b1
) (
  input  logic               sysclk,
  input  logic               reset,
  tweet_buffer_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_SEND, P_GAP} p_state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == FULL_CNT) ? v : v + 1'b1;
  endfunction

  // receiver
  logic             rx_sync_p0, rx_sync_p1, rx_prev;
  logic             rx_fall, rx_tick, rx_done;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_busy_q, frame_err_q;

  // buffer
  logic [7:0]       mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic             overflow_q, full, flush, store_ok, store_wr;

  // transmitter and playback
  logic             tx_busy, tx_out_q, tx_tick, tx_done;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_left;
  logic [8:0]       tx_shift;
  logic             echo_load, play_start, gap_load, tx_load;
  logic [7:0]       tx_data, rd_data;
  p_state_t         p_state;
  logic             playing_q, abort_q;
  logic [CW-1:0]    rd_idx;
  logic [GAP_W-1:0] gap_cnt;

  // ---- stage p0/p1: two-flop synchroniser on the asynchronous serial input
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev    <= 1'b1;
    end else begin
      rx_sync_p0 <= bus.rx_in;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev    <= rx_sync_p1;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync_p1;
  assign rx_tick = (rx_cnt == BIT_LAST);
  assign rx_done = (rx_state == R_STOP) && rx_tick && rx_sync_p1;

  // ---- receiver FSM; start bit is re-checked half a bit after the edge
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_state    <= R_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (!bus.enable) begin
        rx_state  <= R_IDLE;
        rx_cnt    <= '0;
        rx_busy_q <= 1'b0;
      end else begin
        case (rx_state)
          R_IDLE: begin
            if (rx_fall) begin
              rx_state  <= R_START;
              rx_cnt    <= '0;
              rx_busy_q <= 1'b1;
            end
          end
          R_START: begin
            if (rx_cnt == HALF_LAST) begin
              rx_cnt <= '0;
              rx_bit <= '0;
              if (rx_sync_p1) begin
                rx_state  <= R_IDLE;
                rx_busy_q <= 1'b0;
              end else begin
                rx_state <= R_DATA;
              end
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          R_DATA: begin
            if (rx_tick) begin
              rx_cnt <= '0;
              rx_bit <= rx_bit + 1'b1;
              if (rx_bit == 3'd7) rx_state <= R_STOP;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          R_STOP: begin
            if (rx_tick) begin
              rx_state    <= R_IDLE;
              rx_cnt      <= '0;
              rx_busy_q   <= 1'b0;
              frame_err_q <= ~rx_sync_p1;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          default: rx_state <= R_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (bus.enable && rx_state == R_DATA && rx_tick)
      rx_shift <= {rx_sync_p1, rx_shift[7:1]};
  end

  // ---- buffer write side; a byte finishing alongside clear is dropped
  assign full     = (count_q == FULL_CNT);
  assign flush    = bus.clear | ~bus.enable;
  assign store_ok = rx_done & bus.enable & ~bus.clear;
  assign store_wr = store_ok & ~full;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (store_ok) begin
      if (full) overflow_q <= 1'b1;
      else      count_q    <= sat_inc(count_q);
    end
  end

  always_ff @(posedge sysclk) begin
    if (store_wr) mem[count_q[DEPTH_LOG2-1:0]] <= rx_shift;
  end

  assign rd_data = mem[rd_idx[DEPTH_LOG2-1:0]];

  // ---- transmit load arbitration: echo and play start are mutually
  // exclusive because a completing byte keeps rx_busy high that cycle
  always_comb begin
    echo_load  = ECHO && store_wr && !tx_busy && !playing_q;
    play_start = (p_state == P_IDLE) && bus.play && bus.enable && !bus.clear &&
                 (count_q != '0) && !rx_busy_q && !playing_q && !tx_busy;
    gap_load   = (p_state == P_GAP) && (gap_cnt == GAP_LAST) && !flush &&
                 (rd_idx < count_q);
    tx_load    = echo_load | play_start | gap_load;
    tx_data    = echo_load ? rx_shift : rd_data;
  end

  assign tx_tick = (tx_cnt == BIT_LAST);
  assign tx_done = tx_busy && tx_tick && (tx_left == 4'd0);

  // ---- transmitter: start bit driven on load, then 8 data bits and stop
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_busy  <= 1'b0;
      tx_out_q <= 1'b1;
      tx_cnt   <= '0;
      tx_left  <= '0;
    end else if (tx_load) begin
      tx_busy  <= 1'b1;
      tx_out_q <= 1'b0;
      tx_cnt   <= '0;
      tx_left  <= 4'd9;
    end else if (tx_busy) begin
      if (tx_tick) begin
        tx_cnt <= '0;
        if (tx_left == 4'd0) begin
          tx_busy <= 1'b0;
        end else begin
          tx_out_q <= tx_shift[0];
          tx_left  <= tx_left - 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (tx_load)
      tx_shift <= {1'b1, tx_data};
    else if (tx_busy && tx_tick && tx_left != 4'd0)
      tx_shift <= {1'b1, tx_shift[8:1]};
  end

  // ---- playback FSM; a flush lets the current frame finish, then stops
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      p_state   <= P_IDLE;
      playing_q <= 1'b0;
      abort_q   <= 1'b0;
      rd_idx    <= '0;
      gap_cnt   <= '0;
    end else begin
      case (p_state)
        P_IDLE: begin
          abort_q <= 1'b0;
          rd_idx  <= '0;
          if (play_start) begin
            p_state   <= P_SEND;
            playing_q <= 1'b1;
            rd_idx    <= CW'(1);
          end
        end
        P_SEND: begin
          if (flush) abort_q <= 1'b1;
          if (tx_done) begin
            if (abort_q || flush || rd_idx >= count_q) begin
              p_state   <= P_IDLE;
              playing_q <= 1'b0;
            end else begin
              p_state <= P_GAP;
              gap_cnt <= '0;
            end
          end
        end
        P_GAP: begin
          if (flush) begin
            p_state   <= P_IDLE;
            playing_q <= 1'b0;
          end else if (gap_cnt == GAP_LAST) begin
            if (gap_load) begin
              p_state <= P_SEND;
              rd_idx  <= rd_idx + 1'b1;
            end else begin
              p_state   <= P_IDLE;
              playing_q <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          p_state   <= P_IDLE;
          playing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_out    = tx_out_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.rx_busy   = rx_busy_q;
  assign bus.playing   = playing_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_tweet_buffer_ctrl.sv
// Bench for tweet_buffer_ctrl: table of received bytes, directed corner
// sequences and random operations scored against a queue-based buffer model.
module tb_tweet_buffer_ctrl;
  localparam int B     = 16;
  localparam int DL    = 2;
  localparam int G     = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * B;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  always #5 sysclk = ~sysclk;

  tweet_buffer_ctrl_if #(.DEPTH_LOG2(DL)) bus();

  tweet_buffer_ctrl #(.BAUD_DIV(B), .DEPTH_LOG2(DL), .GAP_CYCLES(G), .ECHO(1'b1)) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // serial decoder on tx_out: byte values and start cycles of every frame
  logic [7:0] mon_q[$];
  int         mon_t[$];
  int         mon_bad = 0;
  initial begin
    forever begin
      @(negedge sysclk);
      if (bus.tx_out === 1'b0) begin
        int t0;
        logic [7:0] d;
        t0 = cyc;
        repeat (B / 2) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge sysclk);
          d[i] = bus.tx_out;
        end
        repeat (B) @(negedge sysclk);
        if (bus.tx_out !== 1'b1) mon_bad = mon_bad + 1;
        mon_q.push_back(d);
        mon_t.push_back(t0);
      end
    end
  end

  int   ferr_rise = 0, ferr_hi = 0, play_fall = 0;
  logic ferr_prev = 1'b0, play_prev = 1'b0;
  always @(negedge sysclk) begin
    ferr_prev <= (bus.frame_err === 1'b1);
    play_prev <= (bus.playing === 1'b1);
    if (bus.frame_err === 1'b1) ferr_hi <= ferr_hi + 1;
    if (bus.frame_err === 1'b1 && !ferr_prev) ferr_rise <= ferr_rise + 1;
    if (play_prev && bus.playing !== 1'b1) play_fall <= cyc;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got %0d checks required completion", checks);
    $fatal(1, "watchdog");
  end

  // behavioural model: the buffer is a queue, echoes/replays are byte lists
  logic [7:0] mdl[$];
  logic [7:0] exp_tx[$];
  logic       mdl_ovf = 1'b0;
  int         exp_ferr = 0;

  task automatic model_rx(input logic [7:0] d, input logic ok);
    if (!ok) exp_ferr++;
    else if (mdl.size() < DEPTH) begin mdl.push_back(d); exp_tx.push_back(d); end
    else mdl_ovf = 1'b1;
  endtask

  task automatic model_play();
    foreach (mdl[i]) exp_tx.push_back(mdl[i]);
  endtask

  task automatic model_clear();
    mdl.delete();
    mdl_ovf = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    bus.rx_in = 1'b0;
    repeat (B) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = d[i];
      repeat (B) @(negedge sysclk);
    end
    bus.rx_in = stop;
    repeat (B) @(negedge sysclk);
    bus.rx_in = 1'b1;
  endtask

  task automatic settle();
    repeat (FRAME + 4 * B) @(negedge sysclk);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(negedge sysclk);
    bus.clear = 1'b0;
    model_clear();
    repeat (2) @(negedge sysclk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tx_out"},    int'(bus.tx_out),    1);
    check({tag, "_count"},     int'(bus.count),     0);
    check({tag, "_full"},      int'(bus.full),      0);
    check({tag, "_rx_busy"},   int'(bus.rx_busy),   0);
    check({tag, "_playing"},   int'(bus.playing),   0);
    check({tag, "_overflow"},  int'(bus.overflow),  0);
    check({tag, "_frame_err"}, int'(bus.frame_err), 0);
  endtask

  task automatic compare_state(input string tag);
    check({tag, "_count"},    int'(bus.count),    mdl.size());
    check({tag, "_full"},     int'(bus.full),     int'(mdl.size() == DEPTH));
    check({tag, "_overflow"}, int'(bus.overflow), int'(mdl_ovf));
    check({tag, "_playing"},  int'(bus.playing),  0);
    check({tag, "_tx_idle"},  int'(bus.tx_out),   1);
    check({tag, "_tx_nbytes"}, mon_q.size(), exp_tx.size());
    while (mon_q.size() > 0 && exp_tx.size() > 0)
      check({tag, "_tx_byte"}, int'(mon_q.pop_front()), int'(exp_tx.pop_front()));
    mon_q.delete();
    exp_tx.delete();
  endtask

  task automatic wait_play_end(input string tag);
    int k;
    k = 0;
    while (bus.playing === 1'b1 && k < 2000) begin
      @(negedge sysclk);
      k++;
    end
    check({tag, "_play_ends"}, int'(bus.playing === 1'b1), 0);
    repeat (4) @(negedge sysclk);
  endtask

  task automatic do_play(input string tag);
    int n0, p, n_exp;
    n0 = mon_t.size();
    n_exp = mdl.size();
    p = cyc;
    bus.play = 1'b1;
    @(negedge sysclk);
    bus.play = 1'b0;
    model_play();
    wait_play_end(tag);
    if (n_exp > 0 && mon_t.size() > n0) begin
      check({tag, "_first_start"}, mon_t[n0] - p, 1);
      for (int i = n0 + 1; i < mon_t.size(); i++)
        check({tag, "_char_spacing"}, mon_t[i] - mon_t[i-1], FRAME + G);
      check({tag, "_playing_fall"}, play_fall - mon_t[mon_t.size()-1], FRAME);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_count;
    logic       exp_full;
    logic       exp_ovf;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h30, 1'b1, 1, 1'b0, 1'b0, 0};
    vecs[1] = '{8'h31, 1'b1, 2, 1'b0, 1'b0, 0};
    vecs[2] = '{8'h55, 1'b0, 2, 1'b0, 1'b0, 1};
    vecs[3] = '{8'h32, 1'b1, 3, 1'b0, 1'b0, 0};
    vecs[4] = '{8'h33, 1'b1, 4, 1'b1, 1'b0, 0};
    vecs[5] = '{8'h34, 1'b1, 4, 1'b1, 1'b1, 0};
    vecs[6] = '{8'h35, 1'b0, 4, 1'b1, 1'b1, 1};

    bus.enable = 1'b1;
    bus.clear  = 1'b0;
    bus.play   = 1'b0;
    bus.rx_in  = 1'b1;
    repeat (3) @(negedge sysclk);
    check_reset("rst");
    reset = 1'b0;
    repeat (4) @(negedge sysclk);

    // two stored bytes, echoed, then replayed twice
    send_byte(8'h41, 1'b1); model_rx(8'h41, 1'b1); settle();
    send_byte(8'h42, 1'b1); model_rx(8'h42, 1'b1); settle();
    compare_state("t1");
    do_play("t2a"); compare_state("t2a");
    do_play("t2b"); compare_state("t2b");

    // table: fill, overflow and framing errors from an empty buffer
    pulse_clear();
    compare_state("tab_clr");
    foreach (vecs[i]) begin
      int r0, h0;
      r0 = ferr_rise;
      h0 = ferr_hi;
      send_byte(vecs[i].data, vecs[i].stop);
      model_rx(vecs[i].data, vecs[i].stop);
      settle();
      check($sformatf("tab%0d_count", i),    int'(bus.count),    vecs[i].exp_count);
      check($sformatf("tab%0d_full", i),     int'(bus.full),     int'(vecs[i].exp_full));
      check($sformatf("tab%0d_overflow", i), int'(bus.overflow), int'(vecs[i].exp_ovf));
      check($sformatf("tab%0d_ferr_pulses", i), ferr_rise - r0, vecs[i].exp_ferr);
      check($sformatf("tab%0d_ferr_cycles", i), ferr_hi - h0,   vecs[i].exp_ferr);
      compare_state($sformatf("tab%0d", i));
    end
    do_play("t3"); compare_state("t3");

    // short low glitch is a false start
    begin
      logic seen;
      seen = 1'b0;
      bus.rx_in = 1'b0;
      for (int k = 1; k <= B / 2 + 3; k++) begin
        @(negedge sysclk);
        if (k == 4) bus.rx_in = 1'b1;
        if (bus.rx_busy === 1'b1) seen = 1'b1;
      end
      check("glitch_busy_seen", int'(seen), 1);
      check("glitch_busy_fell", int'(bus.rx_busy), 0);
      settle();
      compare_state("t4");
    end

    // clear during the second frame of a four-character replay
    begin
      bus.play = 1'b1;
      @(negedge sysclk);
      bus.play = 1'b0;
      repeat (FRAME + G + 3 * B) @(negedge sysclk);
      bus.clear = 1'b1;
      @(negedge sysclk);
      bus.clear = 1'b0;
      exp_tx.push_back(mdl[0]);
      exp_tx.push_back(mdl[1]);
      model_clear();
      wait_play_end("t5");
      if (mon_t.size() > 0)
        check("t5_playing_fall", play_fall - mon_t[mon_t.size()-1], FRAME);
      repeat (300) @(negedge sysclk);
      compare_state("t5");
    end

    // asynchronous reset in the middle of a received frame
    send_byte(8'h5A, 1'b1); model_rx(8'h5A, 1'b1); settle();
    compare_state("t6_pre");
    fork
      send_byte(8'hF8, 1'b1);
      begin
        repeat (4 * B + B / 2) @(negedge sysclk);
        check("t6_busy_before", int'(bus.rx_busy), 1);
        #2 reset = 1'b1;
        #1 check_reset("t6_async");
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
      end
    join
    model_clear();
    settle();
    compare_state("t6_post");
    send_byte(8'h7A, 1'b1); model_rx(8'h7A, 1'b1); settle();
    compare_state("t6_store");
    do_play("t6_play"); compare_state("t6_play");

    // random operations against the model
    for (int n = 0; n < 30; n++) begin
      int op;
      logic [7:0] d;
      op = $urandom_range(0, 9);
      d  = 8'($urandom);
      if (op <= 5) begin
        send_byte(d, 1'b1); model_rx(d, 1'b1); settle();
      end else if (op == 6) begin
        send_byte(d, 1'b0); model_rx(d, 1'b0); settle();
      end else if (op <= 8) begin
        do_play($sformatf("rnd%0d", n));
      end else begin
        pulse_clear();
      end
      compare_state($sformatf("rnd%0d", n));
    end

    check("ferr_pulses_total", ferr_rise, exp_ferr);
    check("ferr_cycles_total", ferr_hi, exp_ferr);
    check("tx_stop_bits_bad", mon_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
